// File: rtl/axi_master_pkg.sv
// Shared types and AXI encodings for the single-outstanding AXI4 burst initiator.
package axi_master_pkg;

    // Transaction phases; one burst in flight at a time.
    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StAr,
        StR
    } state_e;

    // AXI burst types.
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    // AXI response codes; OR-combining them lets SLVERR/DECERR dominate OKAY.
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 initiator: turns a command + write/read stream into one INCR burst at a time
// and reports the final AXI response with a one-cycle done pulse.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int unsigned G_DATAWIDTH = 32,
    parameter int unsigned G_ADDRWIDTH = 10,
    parameter int unsigned G_ID_WIDTH  = 1,
    parameter int unsigned G_ID_VALUE  = 0
) (
    input  logic                     s_aclk,
    input  logic                     s_aresetn,
    // Command interface
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [G_ADDRWIDTH-1:0]   cmd_addr,
    input  logic [7:0]               cmd_len,
    // Write payload stream
    input  logic [G_DATAWIDTH-1:0]   wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    // Read payload stream
    output logic [G_DATAWIDTH-1:0]   rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     rd_last,
    // Completion / status
    output logic                     done,
    output logic [1:0]               done_resp,
    output logic                     proto_err,
    // AXI write address channel
    output logic [G_ID_WIDTH-1:0]    m_axi_awid,
    output logic [G_ADDRWIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]               m_axi_awlen,
    output logic [2:0]               m_axi_awsize,
    output logic [1:0]               m_axi_awburst,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    // AXI write data channel
    output logic [G_DATAWIDTH-1:0]   m_axi_wdata,
    output logic [G_DATAWIDTH/8-1:0] m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    // AXI write response channel
    input  logic [G_ID_WIDTH-1:0]    m_axi_bid,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    // AXI read address channel
    output logic [G_ID_WIDTH-1:0]    m_axi_arid,
    output logic [G_ADDRWIDTH-1:0]   m_axi_araddr,
    output logic [7:0]               m_axi_arlen,
    output logic [2:0]               m_axi_arsize,
    output logic [1:0]               m_axi_arburst,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    // AXI read data channel
    input  logic [G_ID_WIDTH-1:0]    m_axi_rid,
    input  logic [G_DATAWIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam logic [G_ID_WIDTH-1:0] IdVal  = G_ID_WIDTH'(G_ID_VALUE);
    localparam logic [2:0]            AxSize = 3'($clog2(G_DATAWIDTH / 8));

    state_e                 state_q, state_d;
    logic [G_ADDRWIDTH-1:0] addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [7:0]             beat_q, beat_d;
    logic [1:0]             resp_acc_q, resp_acc_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   done_q, done_d;
    logic [1:0]             done_resp_q, done_resp_d;
    logic                   proto_err_q, proto_err_d;

    // Single-ID initiator: returned IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    logic last_beat;
    assign last_beat = (beat_q == len_q);

    // State and datapath registers; reset drops every valid at once.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            resp_acc_q  <= RespOkay;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= RespOkay;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            resp_acc_q  <= resp_acc_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state, beat counting, response accumulation and protocol checking.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        resp_acc_d  = resp_acc_q;
        cmd_ready_d = 1'b0;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        proto_err_d = proto_err_q;

        unique case (state_q)
            StIdle: begin
                // cmd_ready rises one cycle after entering idle, i.e. one cycle after done.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    len_d       = cmd_len;
                    beat_d      = '0;
                    resp_acc_d  = RespOkay;
                    cmd_ready_d = 1'b0;
                    state_d     = cmd_write ? StAw : StAr;
                end
            end
            StAw: begin
                if (m_axi_awready) begin
                    state_d = StW;
                end
            end
            StW: begin
                if (wr_valid && m_axi_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = StB;
                    end
                end
            end
            StB: begin
                if (m_axi_bvalid) begin
                    done_d      = 1'b1;
                    done_resp_d = m_axi_bresp;
                    state_d     = StIdle;
                end
            end
            StAr: begin
                if (m_axi_arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (m_axi_rvalid && rd_ready) begin
                    beat_d     = beat_q + 8'd1;
                    resp_acc_d = resp_acc_q | m_axi_rresp;
                    if (m_axi_rlast) begin
                        if (!last_beat) begin
                            proto_err_d = 1'b1;
                        end
                        done_d      = 1'b1;
                        done_resp_d = resp_acc_d;
                        state_d     = StIdle;
                    end else if (last_beat) begin
                        // Missing rlast: flag it but keep draining until the responder ends.
                        proto_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Command / status outputs
    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign proto_err = proto_err_q;

    // Write address channel
    assign m_axi_awid    = IdVal;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AxSize;
    assign m_axi_awburst = BurstIncr;
    assign m_axi_awvalid = (state_q == StAw);

    // Write data channel passes the stream straight through while in W
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = '1;
    assign m_axi_wvalid = (state_q == StW) && wr_valid;
    assign m_axi_wlast  = (state_q == StW) && last_beat;
    assign wr_ready     = (state_q == StW) && m_axi_wready;

    // Write response channel
    assign m_axi_bready = (state_q == StB);

    // Read address channel
    assign m_axi_arid    = IdVal;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AxSize;
    assign m_axi_arburst = BurstIncr;
    assign m_axi_arvalid = (state_q == StAr);

    // Read data channel passes through to the stream while in R
    assign rd_data      = m_axi_rdata;
    assign rd_valid     = (state_q == StR) && m_axi_rvalid;
    assign rd_last      = (state_q == StR) && m_axi_rlast;
    assign m_axi_rready = (state_q == StR) && rd_ready;

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 full initiator: converts a simple command/stream interface into single-ID INCR bursts toward an AXI4 memory responder.
- Write commands take payload from a write stream; read commands return data on a read stream.
- One transaction is outstanding at a time; a completion pulse reports the AXI response.
- Sits between DMA-style control logic and the shared block-memory AXI slaves.

Parameters:
- G_DATAWIDTH, 32, data bus width in bits (multiple of 8).
- G_ADDRWIDTH, 10, byte address width.
- G_ID_WIDTH, 1, AXI ID width.
- G_ID_VALUE, 0, constant driven on awid/arid.

Ports:
- s_aclk  in  1  clock.
- s_aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  G_ADDRWIDTH  start byte address.
- cmd_len  in  8  beats minus 1 (AXI len encoding).
- wr_data/wr_valid/wr_ready  in/in/out  G_DATAWIDTH/1/1  write payload stream.
- rd_data/rd_valid/rd_ready/rd_last  out/out/in/out  G_DATAWIDTH/1/1/1  read payload stream.
- done  out  1  one-cycle pulse at transaction end.
- done_resp  out  2  final response; held until next done.
- proto_err  out  1  sticky, set on rlast mismatch; cleared only by reset.
- m_axi_aw{id,addr,len,size,burst,valid}, m_axi_awready  AXI4 write address channel (out, ready in).
- m_axi_w{data,strb,last,valid}, m_axi_wready  write data channel.
- m_axi_b{id,resp,valid}, m_axi_bready  write response channel.
- m_axi_ar{id,addr,len,size,burst,valid}, m_axi_arready  read address channel.
- m_axi_r{id,data,resp,last,valid}, m_axi_rready  read data channel.

Behaviour:
- Reset (async assert, sync release): state IDLE; all valids, readies, done, done_resp, proto_err and counters = 0.
- States: IDLE, AW, W, B, AR, R.
- IDLE:
  - cmd_ready=1 (registered; 0 during reset).
  - On cmd_valid&cmd_ready: latch addr and len, clear beat count, go AW if cmd_write else AR.
  - awvalid/arvalid assert the next cycle.
- AW/AR:
  - Hold awvalid/arvalid with stable addr, len=latched len, size=clog2(G_DATAWIDTH/8), burst=INCR (2'b01), id=G_ID_VALUE.
  - On ready, drop valid and go W/R. Address valid never depends on ready.
- W:
  - wvalid=wr_valid, wdata=wr_data, wr_ready=m_axi_wready, wstrb all ones.
  - wlast=1 when beat count == latched len.
  - Each wvalid&wready increments the count. The last-beat handshake goes to B.
  - Stream stall: wr_valid low means wvalid low, no beat.
- B:
  - bready=1.
  - On bvalid: done_resp=bresp, done pulses the next cycle, go IDLE. bid is ignored.
- R:
  - rd_valid=rvalid, rd_data=rdata, rd_last=rlast, rready=rd_ready.
  - Accumulate worst response: OR of rresp bits, so SLVERR/DECERR dominate.
  - Each rvalid&rready increments the count.
  - Exit R on the handshake where rlast=1: done pulse, done_resp=accumulated value, go IDLE.
  - If rlast arrives with count != len, or count == len without rlast, set proto_err. In the second case stay in R until rlast.
- Latency: cmd accept → awvalid/arvalid 1 cycle. Final handshake → done 1 cycle. Next cmd_ready 1 cycle after done.
- No 4 KB boundary splitting; the caller guarantees legality. Address wraps modulo 2^G_ADDRWIDTH.
- cmd_valid while busy is ignored (cmd_ready=0).
- Reset mid-burst: all valids drop immediately (async). The responder must also be reset.

Decomposition:
- Package axi_master_pkg: state enum, AXI burst constants (FIXED/INCR/WRAP), resp codes (OKAY, EXOKAY, SLVERR, DECERR).
- Single module, no sub-module.
- The beat counter and channel logic stay inline (~250 lines).

Test Plan:
- Write addr 0x010, len 0, data 0xA5A5_0001 → one AW with awlen=0, awsize=2, awburst=1; single W beat with wlast=1; done pulse with done_resp=0.
- Write addr 0x040, len 3, data 1..4; read back the same → rd_data 1,2,3,4 with rd_last on the 4th beat; done_resp=0.
- Read len 7 with rd_ready toggling 1-0-1-0 → exactly 8 beats, order preserved, rready mirrors rd_ready.
- Responder returns bresp=2'b10 → done_resp=2'b10; the next command still completes with 0.
- Responder asserts rlast on beat 2 of a len=3 read → proto_err=1, done pulses, FSM returns to IDLE.
- Deassert s_aresetn during beat 2 of a len=5 write → wvalid/awvalid=0 asynchronously; after release cmd_ready=1 and a fresh write completes.
